// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchronizer and counter debouncer for a raw pushbutton,
// with registered press, release and long-press pulses.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES   = 1000,
   parameter int LONG_PRESS_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic button_raw,
   output logic button,
   output logic pressed,
   output logic released,
   output logic long_press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
   logic sync1_q, sync2_q, button_q, button_d, flip;
   logic pressed_q, pressed_d, released_q, released_d, long_q, long_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   always_comb begin
      flip       = (sync2_q != button_q) && (cnt_q == CNT_LAST);
      cnt_d      = (sync2_q == button_q || flip) ? '0 : cnt_q + CW'(1);
      button_d   = flip ? sync2_q : button_q;
      pressed_d  = flip && sync2_q;
      released_d = flip && !sync2_q;
      // hold count only advances while the debounced level is already high, so it restarts on each press
      hcnt_d     = !button_q ? '0 : (hcnt_q < HOLD_MAX ? hcnt_q + HW'(1) : hcnt_q);
      long_d     = button_q && (hcnt_q == HOLD_LAST);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         {sync1_q, sync2_q, button_q, pressed_q, released_q, long_q} <= '0;
         cnt_q  <= '0;
         hcnt_q <= '0;
      end else begin
         sync1_q    <= button_raw;
         sync2_q    <= sync1_q;
         button_q   <= button_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
         long_q     <= long_d;
         cnt_q      <= cnt_d;
         hcnt_q     <= hcnt_d;
      end
   assign button     = button_q;
   assign pressed    = pressed_q;
   assign released   = released_q;
   assign long_press = long_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scenario tasks plus randomized runs, checked every cycle against a
// sliding-window reference model of the debouncer.
module tb_button_debouncer;
   localparam int D = 4;
   localparam int L = 16;
   logic clk = 0, reset_n = 1, button_raw = 0;
   logic button, pressed, released, long_press;
   int checks = 0, errors = 0;
   bit m_s1, m_s, m_btn, m_pr, m_rl, m_lp;
   bit hist[$];
   int hold, cyc, n_pr, n_rl, n_lp, pr_cyc, rl_cyc, lp_cyc;

   button_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
      .clk(clk), .reset_n(reset_n), .button_raw(button_raw), .button(button),
      .pressed(pressed), .released(released), .long_press(long_press)
   );

   always #5 clk = ~clk;

   // Level flips once the last D synchronized samples all disagree with it.
   task automatic tick(input bit raw);
      bit stable;
      button_raw = raw;
      @(posedge clk);
      cyc++;
      m_pr = 0; m_rl = 0; m_lp = 0;
      if (m_btn) begin hold++; m_lp = (hold == L); end else hold = 0;
      hist.push_back(m_s);
      if (hist.size() > D) void'(hist.pop_front());
      stable = (hist.size() == D);
      foreach (hist[i]) if (hist[i] == m_btn) stable = 0;
      if (stable) begin m_btn = !m_btn; m_pr = m_btn; m_rl = !m_btn; end
      m_s = m_s1; m_s1 = raw;
      #1;
      checks++;
      if ({button, pressed, released, long_press} !== {m_btn, m_pr, m_rl, m_lp}) begin
         errors++;
         $display("FAIL outputs cyc %0d: btn/pr/rl/lp got %b required %b", cyc,
                  {button, pressed, released, long_press}, {m_btn, m_pr, m_rl, m_lp});
      end
      if (pressed) begin n_pr++; pr_cyc = cyc; end
      if (released) begin n_rl++; rl_cyc = cyc; end
      if (long_press) begin n_lp++; lp_cyc = cyc; end
   endtask

   task automatic do_reset;
      reset_n = 0;
      #1;
      checks++;
      if ({button, pressed, released, long_press} !== 4'b0) begin
         errors++;
         $display("FAIL reset_immediate: got %b required 0000", {button, pressed, released, long_press});
      end
      m_s1 = 0; m_s = 0; m_btn = 0; m_pr = 0; m_rl = 0; m_lp = 0; hist.delete(); hold = 0;
      repeat (2) begin @(posedge clk); cyc++; end
      #1;
      checks++;
      if ({button, pressed, released, long_press} !== 4'b0) begin
         errors++;
         $display("FAIL reset_hold: got %b required 0000", {button, pressed, released, long_press});
      end
      reset_n = 1;
   endtask

   task automatic test_reset;
      do_reset();
      repeat (6) tick(0);
   endtask

   task automatic test_clean_press;
      int p0, r0, l0, edge_n;
      repeat (4) tick(0);
      p0 = n_pr; r0 = n_rl; l0 = n_lp; pr_cyc = -1;
      edge_n = cyc + 1;
      repeat (12) tick(1);
      checks++;
      if (pr_cyc !== edge_n + D + 1) begin
         errors++; $display("FAIL press_latency: got cyc %0d required %0d", pr_cyc, edge_n + D + 1);
      end
      checks++;
      if (n_pr - p0 !== 1) begin errors++; $display("FAIL press_count: got %0d required 1", n_pr - p0); end
      checks++;
      if (n_rl != r0 || n_lp != l0) begin
         errors++; $display("FAIL press_side_pulses: got rl %0d lp %0d required 0 0", n_rl - r0, n_lp - l0);
      end
   endtask

   task automatic test_bounce;
      int p0, edge_n;
      repeat (10) tick(0);
      p0 = n_pr;
      for (int i = 0; i < 20; i++) tick(((i / 2) % 2) == 0);
      checks++;
      if (n_pr != p0 || button !== 1'b0) begin
         errors++; $display("FAIL bounce_stable: got pulses %0d btn %b required 0 0", n_pr - p0, button);
      end
      pr_cyc = -1;
      edge_n = cyc + 1;
      repeat (10) tick(1);
      checks++;
      if (pr_cyc !== edge_n + D + 1) begin
         errors++; $display("FAIL bounce_latency: got cyc %0d required %0d", pr_cyc, edge_n + D + 1);
      end
      checks++;
      if (n_pr - p0 !== 1) begin errors++; $display("FAIL bounce_count: got %0d required 1", n_pr - p0); end
   endtask

   task automatic test_glitch;
      int p0, r0;
      repeat (10) tick(0);
      p0 = n_pr;
      repeat (3) tick(1);
      repeat (10) tick(0);
      checks++;
      if (n_pr != p0 || button !== 1'b0) begin
         errors++; $display("FAIL glitch_high: got pulses %0d btn %b required 0 0", n_pr - p0, button);
      end
      repeat (12) tick(1);
      r0 = n_rl;
      repeat (3) tick(0);
      repeat (10) tick(1);
      checks++;
      if (n_rl != r0 || button !== 1'b1) begin
         errors++; $display("FAIL glitch_low: got pulses %0d btn %b required 0 1", n_rl - r0, button);
      end
   endtask

   task automatic test_long_press;
      int l0, fall;
      repeat (10) tick(0);
      l0 = n_lp; pr_cyc = -1; lp_cyc = -1; rl_cyc = -1;
      repeat (40) tick(1);
      fall = cyc + 1;
      repeat (15) tick(0);
      checks++;
      if (pr_cyc < 0 || lp_cyc !== pr_cyc + L) begin
         errors++; $display("FAIL long_latency: got lp cyc %0d required %0d", lp_cyc, pr_cyc + L);
      end
      checks++;
      if (n_lp - l0 !== 1) begin errors++; $display("FAIL long_count: got %0d required 1", n_lp - l0); end
      checks++;
      if (rl_cyc !== fall + D + 1) begin
         errors++; $display("FAIL release_latency: got cyc %0d required %0d", rl_cyc, fall + D + 1);
      end
   endtask

   task automatic test_short_press;
      int p0, r0, l0;
      repeat (10) tick(0);
      p0 = n_pr; r0 = n_rl; l0 = n_lp;
      repeat (10) tick(1);
      repeat (12) tick(0);
      checks++;
      if (n_pr - p0 !== 1 || n_rl - r0 !== 1 || n_lp != l0) begin
         errors++;
         $display("FAIL short_press: got pr %0d rl %0d lp %0d required 1 1 0", n_pr - p0, n_rl - r0, n_lp - l0);
      end
   endtask

   task automatic test_reset_mid_press;
      int p0, rise;
      repeat (12) tick(1);
      checks++;
      if (button !== 1'b1) begin errors++; $display("FAIL mid_press_setup: got %b required 1", button); end
      p0 = n_pr;
      do_reset();
      rise = cyc; pr_cyc = -1;
      repeat (10) tick(1);
      checks++;
      if (pr_cyc !== rise + D + 2) begin
         errors++; $display("FAIL reset_repress_latency: got cyc %0d required %0d", pr_cyc, rise + D + 2);
      end
      checks++;
      if (n_pr - p0 !== 1) begin errors++; $display("FAIL reset_repress_count: got %0d required 1", n_pr - p0); end
   endtask

   task automatic test_random;
      for (int r = 0; r < 80; r++) begin
         bit v;
         int len;
         v = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(L, 2 * L) : $urandom_range(1, D + 2);
         repeat (len) tick(v);
      end
      repeat (12) tick(0);
   endtask

   initial begin
      #1;
      test_reset();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_long_press();
      test_short_press();
      test_reset_mid_press();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
